// File: rtl/demux21_buf_if.sv
// demux21_buf_if: bundles the producer stream, both consumer streams and
// the delivery counters of the 1:2 buffered demultiplexer.
// master = producer/consumer side, slave = the demultiplexer itself.
interface demux21_buf_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] D;
   logic             S;
   logic             out1_valid;
   logic             out1_ready;
   logic [WIDTH-1:0] Y1;
   logic             out2_valid;
   logic             out2_ready;
   logic [WIDTH-1:0] Y2;
   logic [15:0]      cnt1;
   logic [15:0]      cnt2;

   modport master (
      output in_valid, D, S, out1_ready, out2_ready,
      input  in_ready, out1_valid, Y1, out2_valid, Y2, cnt1, cnt2
   );

   modport slave (
      input  in_valid, D, S, out1_ready, out2_ready,
      output in_ready, out1_valid, Y1, out2_valid, Y2, cnt1, cnt2
   );
endinterface

// File: rtl/demux21_buf.sv
// demux21_buf: registered 1:2 demultiplexer. Each word on the input stream
// is steered by S into one of two independent 2-entry FIFOs (S=0 -> output 1,
// S=1 -> output 2), so a stalled consumer never blocks the other one.
// Optional feature: define DEMUX21_COUNT_EN to build the per-output delivery
// counters cnt1/cnt2; otherwise they read as zero.
module demux21_buf #(
   parameter int WIDTH = 32
) (
   input logic         clk,
   input logic         rst_n,
   demux21_buf_if.slave bus
);

   logic [WIDTH-1:0] mem1 [2];
   logic [WIDTH-1:0] mem2 [2];
   logic             head1, tail1, head2, tail2;
   logic [1:0]       occ1, occ2;
   logic             push1, push2, pop1, pop2;

   // Handshake decode: in_ready looks only at S and registered occupancy,
   // keeping the consumer readies out of the producer-side timing path.
   always_comb begin
      bus.in_ready   = bus.S ? (occ2 != 2'd2) : (occ1 != 2'd2);
      bus.out1_valid = (occ1 != 2'd0);
      bus.out2_valid = (occ2 != 2'd0);
      bus.Y1         = (occ1 != 2'd0) ? mem1[head1] : '0;
      bus.Y2         = (occ2 != 2'd0) ? mem2[head2] : '0;
      push1          = bus.in_valid & bus.in_ready & ~bus.S;
      push2          = bus.in_valid & bus.in_ready &  bus.S;
      pop1           = bus.out1_valid & bus.out1_ready;
      pop2           = bus.out2_valid & bus.out2_ready;
   end

   // FIFO 1: write at tail, read at head; simultaneous push/pop keeps occupancy.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         occ1    <= 2'd0;
         head1   <= 1'b0;
         tail1   <= 1'b0;
         mem1[0] <= '0;
         mem1[1] <= '0;
      end else begin
         if (push1) begin
            mem1[tail1] <= bus.D;
            tail1       <= ~tail1;
         end
         if (pop1) head1 <= ~head1;
         case ({push1, pop1})
            2'b10:   occ1 <= occ1 + 2'd1;
            2'b01:   occ1 <= occ1 - 2'd1;
            default: occ1 <= occ1;
         endcase
      end
   end

   // FIFO 2: same structure as FIFO 1, fed when S=1.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         occ2    <= 2'd0;
         head2   <= 1'b0;
         tail2   <= 1'b0;
         mem2[0] <= '0;
         mem2[1] <= '0;
      end else begin
         if (push2) begin
            mem2[tail2] <= bus.D;
            tail2       <= ~tail2;
         end
         if (pop2) head2 <= ~head2;
         case ({push2, pop2})
            2'b10:   occ2 <= occ2 + 2'd1;
            2'b01:   occ2 <= occ2 - 2'd1;
            default: occ2 <= occ2;
         endcase
      end
   end

`ifdef DEMUX21_COUNT_EN
   logic [15:0] count1, count2;

   // Delivery counters: one increment per pop, natural 16-bit wrap.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count1 <= 16'h0000;
         count2 <= 16'h0000;
      end else begin
         if (pop1) count1 <= count1 + 16'd1;
         if (pop2) count2 <= count2 + 16'd1;
      end
   end

   assign bus.cnt1 = count1;
   assign bus.cnt2 = count2;
`else
   assign bus.cnt1 = 16'h0000;
   assign bus.cnt2 = 16'h0000;
`endif

endmodule

// File: tb/tb_demux21_buf.sv
// tb_demux21_buf: self-checking bench for demux21_buf. A queue-per-output
// reference model tracks what each consumer should see.
module tb_demux21_buf;
   localparam int WIDTH = 32;

   logic clk = 1'b0;
   logic rst_n;
   int   errors = 0;
   int   checks = 0;

   logic [WIDTH-1:0] q1[$];
   logic [WIDTH-1:0] q2[$];
   logic [15:0]      m_cnt1 = 16'h0;
   logic [15:0]      m_cnt2 = 16'h0;

   always #5 clk = ~clk;

   demux21_buf_if #(.WIDTH(WIDTH)) bus ();

   demux21_buf #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Advance one clock edge and apply the same edge to the reference model.
   task automatic cycle();
      bit               rst_now, acc, p1, p2, sel;
      logic [WIDTH-1:0] d, tmp;
      rst_now = !rst_n;
      sel     = bus.S;
      d       = bus.D;
      acc     = bus.in_valid && ((sel ? q2.size() : q1.size()) != 2);
      p1      = (q1.size() != 0) && bus.out1_ready;
      p2      = (q2.size() != 0) && bus.out2_ready;
      @(posedge clk);
      if (rst_now) begin
         q1.delete();
         q2.delete();
         m_cnt1 = 16'h0;
         m_cnt2 = 16'h0;
      end else begin
         if (p1) begin
            tmp = q1.pop_front();
`ifdef DEMUX21_COUNT_EN
            m_cnt1 = m_cnt1 + 16'd1;
`endif
         end
         if (p2) begin
            tmp = q2.pop_front();
`ifdef DEMUX21_COUNT_EN
            m_cnt2 = m_cnt2 + 16'd1;
`endif
         end
         if (acc) begin
            if (sel) q2.push_back(d);
            else     q1.push_back(d);
         end
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.in_valid = 1'b1; bus.S = 1'b0; bus.D = 32'hDEAD_BEEF;
      bus.out1_ready = 1'b0; bus.out2_ready = 1'b0;
      @(negedge clk);
      cycle();
      cycle();
      #1;
      checks++; if (bus.out1_valid !== 1'b0) begin errors++; $display("FAIL reset_out1_valid: got %b want 0", bus.out1_valid); end
      checks++; if (bus.out2_valid !== 1'b0) begin errors++; $display("FAIL reset_out2_valid: got %b want 0", bus.out2_valid); end
      checks++; if (bus.Y1 !== 32'h0) begin errors++; $display("FAIL reset_Y1: got %h want 0", bus.Y1); end
      checks++; if (bus.Y2 !== 32'h0) begin errors++; $display("FAIL reset_Y2: got %h want 0", bus.Y2); end
      checks++; if (bus.cnt1 !== 16'h0 || bus.cnt2 !== 16'h0) begin errors++; $display("FAIL reset_cnt: got %h/%h want 0/0", bus.cnt1, bus.cnt2); end
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
      rst_n = 1'b1; bus.in_valid = 1'b0;
      cycle();
      #1;
      checks++; if (bus.out1_valid !== 1'b0 || bus.out2_valid !== 1'b0) begin errors++; $display("FAIL reset_nothing_stored: got %b/%b want 0/0", bus.out1_valid, bus.out2_valid); end
   endtask

   task automatic test_routing();
      bus.out1_ready = 1'b1; bus.out2_ready = 1'b1;
      bus.in_valid = 1'b1; bus.S = 1'b0; bus.D = 32'hAAAA_0001;
      #1;
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL route_ready1: got %b want 1", bus.in_ready); end
      cycle();
      checks++; if (bus.out1_valid !== 1'b1 || bus.Y1 !== 32'hAAAA_0001) begin errors++; $display("FAIL route_Y1: got v=%b %h want v=1 aaaa0001", bus.out1_valid, bus.Y1); end
      checks++; if (bus.out2_valid !== 1'b0) begin errors++; $display("FAIL route_out2_idle: got %b want 0", bus.out2_valid); end
      bus.S = 1'b1; bus.D = 32'h5555_0002;
      cycle();
      checks++; if (bus.out2_valid !== 1'b1 || bus.Y2 !== 32'h5555_0002) begin errors++; $display("FAIL route_Y2: got v=%b %h want v=1 55550002", bus.out2_valid, bus.Y2); end
      checks++; if (bus.out1_valid !== 1'b0 || bus.Y1 !== 32'h0) begin errors++; $display("FAIL route_out1_drained: got v=%b %h want v=0 0", bus.out1_valid, bus.Y1); end
      bus.in_valid = 1'b0;
      cycle();
      checks++; if (bus.out2_valid !== 1'b0) begin errors++; $display("FAIL route_out2_drained: got %b want 0", bus.out2_valid); end
   endtask

   task automatic test_backpressure();
      bus.out1_ready = 1'b0; bus.out2_ready = 1'b1;
      bus.in_valid = 1'b1; bus.S = 1'b0; bus.D = 32'hA1;
      #1;
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_w1: got %b want 1", bus.in_ready); end
      cycle();
      bus.D = 32'hA2;
      #1;
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_w2: got %b want 1", bus.in_ready); end
      cycle();
      bus.D = 32'hA3;
      #1;
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_full: got %b want 0", bus.in_ready); end
      cycle();
      #1;
      checks++; if (bus.in_ready !== 1'b0 || bus.Y1 !== 32'hA1) begin errors++; $display("FAIL bp_held: got rdy=%b Y1=%h want rdy=0 Y1=a1", bus.in_ready, bus.Y1); end
      bus.in_valid = 1'b0;
      cycle();
      bus.in_valid = 1'b1; bus.S = 1'b1; bus.D = 32'hB1;
      #1;
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_isolation_ready: got %b want 1", bus.in_ready); end
      cycle();
      checks++; if (bus.out2_valid !== 1'b1 || bus.Y2 !== 32'hB1) begin errors++; $display("FAIL bp_isolation_Y2: got v=%b %h want v=1 b1", bus.out2_valid, bus.Y2); end
      bus.S = 1'b0; bus.D = 32'hA3; bus.out1_ready = 1'b1;
      #1;
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_retry_blocked: got %b want 0", bus.in_ready); end
      cycle();
      #1;
      checks++; if (bus.Y1 !== 32'hA2 || bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_drain_a2: got Y1=%h rdy=%b want a2 1", bus.Y1, bus.in_ready); end
      cycle();
      checks++; if (bus.Y1 !== 32'hA3) begin errors++; $display("FAIL bp_drain_a3: got %h want a3", bus.Y1); end
      bus.in_valid = 1'b0;
      cycle();
      checks++; if (bus.out1_valid !== 1'b0 || bus.out2_valid !== 1'b0) begin errors++; $display("FAIL bp_empty: got %b/%b want 0/0", bus.out1_valid, bus.out2_valid); end
   endtask

   task automatic test_streaming();
      bus.out1_ready = 1'b1; bus.out2_ready = 1'b1;
      bus.in_valid = 1'b1; bus.S = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         bus.D = WIDTH'(i);
         #1;
         checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL stream_ready[%0d]: got %b want 1", i, bus.in_ready); end
         cycle();
         checks++; if (bus.out1_valid !== 1'b1 || bus.Y1 !== WIDTH'(i)) begin errors++; $display("FAIL stream_Y1[%0d]: got v=%b %h want v=1 %h", i, bus.out1_valid, bus.Y1, WIDTH'(i)); end
         checks++; if (dut.occ1 > 2'd1) begin errors++; $display("FAIL stream_occ1[%0d]: got %0d want <=1", i, dut.occ1); end
      end
      bus.in_valid = 1'b0;
      cycle();
   endtask

   task automatic test_reset_midstream();
      bus.out1_ready = 1'b0;
      bus.in_valid = 1'b1; bus.S = 1'b0; bus.D = 32'h11;
      cycle();
      bus.D = 32'h22;
      cycle();
      bus.in_valid = 1'b0;
      #1;
      checks++; if (bus.out1_valid !== 1'b1 || bus.Y1 !== 32'h11) begin errors++; $display("FAIL mid_filled: got v=%b %h want v=1 11", bus.out1_valid, bus.Y1); end
      rst_n = 1'b0;
      cycle();
      #1;
      checks++; if (bus.out1_valid !== 1'b0 || bus.Y1 !== 32'h0 || bus.in_ready !== 1'b1) begin errors++; $display("FAIL mid_reset: got v=%b Y1=%h rdy=%b want 0 0 1", bus.out1_valid, bus.Y1, bus.in_ready); end
      rst_n = 1'b1;
      bus.in_valid = 1'b1; bus.D = 32'h33;
      cycle();
      bus.in_valid = 1'b0; bus.out1_ready = 1'b1;
      #1;
      checks++; if (bus.out1_valid !== 1'b1 || bus.Y1 !== 32'h33) begin errors++; $display("FAIL mid_first_pop: got v=%b %h want v=1 33", bus.out1_valid, bus.Y1); end
      cycle();
      checks++; if (bus.out1_valid !== 1'b0) begin errors++; $display("FAIL mid_empty: got %b want 0", bus.out1_valid); end
   endtask

   task automatic test_random();
      bit               blocked;
      logic [WIDTH-1:0] e1, e2;
      blocked = 1'b0;
      for (int n = 0; n < 400; n++) begin
         rst_n = ($urandom_range(63) != 0);
         if (!blocked) begin
            bus.in_valid = $urandom_range(3) != 0;
            bus.S        = $urandom_range(1);
            bus.D        = $urandom;
         end
         bus.out1_ready = $urandom_range(2) != 0;
         bus.out2_ready = $urandom_range(3) == 0;
         #1;
         e1 = (q1.size() != 0) ? q1[0] : '0;
         e2 = (q2.size() != 0) ? q2[0] : '0;
         checks++; if (bus.in_ready !== ((bus.S ? q2.size() : q1.size()) != 2)) begin errors++; $display("FAIL rand_in_ready[%0d]: got %b want %b", n, bus.in_ready, ((bus.S ? q2.size() : q1.size()) != 2)); end
         checks++; if (bus.out1_valid !== (q1.size() != 0) || bus.Y1 !== e1) begin errors++; $display("FAIL rand_out1[%0d]: got v=%b %h want v=%b %h", n, bus.out1_valid, bus.Y1, (q1.size() != 0), e1); end
         checks++; if (bus.out2_valid !== (q2.size() != 0) || bus.Y2 !== e2) begin errors++; $display("FAIL rand_out2[%0d]: got v=%b %h want v=%b %h", n, bus.out2_valid, bus.Y2, (q2.size() != 0), e2); end
         checks++; if (bus.cnt1 !== m_cnt1 || bus.cnt2 !== m_cnt2) begin errors++; $display("FAIL rand_cnt[%0d]: got %h/%h want %h/%h", n, bus.cnt1, bus.cnt2, m_cnt1, m_cnt2); end
         blocked = rst_n && bus.in_valid && ((bus.S ? q2.size() : q1.size()) == 2);
         cycle();
      end
      rst_n = 1'b1; bus.in_valid = 1'b0; bus.out1_ready = 1'b1; bus.out2_ready = 1'b1;
      cycle(); cycle(); cycle();
   endtask

   task automatic test_count();
      rst_n = 1'b0; bus.in_valid = 1'b0;
      cycle();
      rst_n = 1'b1;
      bus.out1_ready = 1'b0; bus.out2_ready = 1'b1;
      bus.in_valid = 1'b1; bus.S = 1'b1;
`ifdef DEMUX21_COUNT_EN
      for (int i = 0; i < 32'h10001; i++) begin
         bus.D = WIDTH'(i);
         cycle();
      end
      bus.in_valid = 1'b0;
      cycle();
      checks++; if (bus.cnt2 !== 16'h0001) begin errors++; $display("FAIL count_wrap_cnt2: got %h want 0001", bus.cnt2); end
`else
      for (int i = 0; i < 5; i++) begin
         bus.D = WIDTH'(i);
         cycle();
      end
      bus.in_valid = 1'b0;
      cycle();
      checks++; if (bus.cnt2 !== 16'h0000) begin errors++; $display("FAIL count_tied_cnt2: got %h want 0000", bus.cnt2); end
`endif
      checks++; if (bus.cnt1 !== 16'h0000) begin errors++; $display("FAIL count_cnt1: got %h want 0000", bus.cnt1); end
      checks++; if (bus.cnt2 !== m_cnt2) begin errors++; $display("FAIL count_model_cnt2: got %h want %h", bus.cnt2, m_cnt2); end
   endtask

   initial begin
      rst_n = 1'b0;
      bus.in_valid = 1'b0; bus.S = 1'b0; bus.D = '0;
      bus.out1_ready = 1'b0; bus.out2_ready = 1'b0;
      test_reset();
      test_routing();
      test_backpressure();
      test_streaming();
      test_reset_midstream();
      test_random();
      test_count();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
